// File: rtl/hybrid_pq_pkg.sv
// Shared types and helpers for the banked hybrid priority queue.
package hybrid_pq_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_e;

  localparam int PRIO_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // True when a strictly outranks b under the selected ordering.
  function automatic logic prio_gt(input logic [PRIO_W-1:0] a,
                                   input logic [PRIO_W-1:0] b,
                                   input logic max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/hybrid_pq_banked_bank.sv
// One sorted storage bank: entry 0 is the top, valid bits mark live entries.
module pq_bank
  import hybrid_pq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BANK_DEPTH = 8,
  parameter int MAX_FIRST  = 1
) (
  input  logic                                CLK,
  input  logic                                RSTn,
  input  logic [1:0]                          op,
  input  logic [DATA_WIDTH-1:0]               data,
  output logic [DATA_WIDTH-1:0]               top,
  output logic                                top_valid,
  output logic [$clog2(BANK_DEPTH+1)-1:0]     count,
  output logic                                full
);

  localparam int CW = $clog2(BANK_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem     [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] src     [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] mem_nxt [BANK_DEPTH];
  logic [BANK_DEPTH-1:0] vld, src_vld, vld_nxt, keep;
  logic                  shift, ins;

  assign shift = (op == OP_POP)  || (op == OP_REPL);
  assign ins   = (op == OP_PUSH) || (op == OP_REPL);

  // Replace removes the top first, so insertion is computed on the shifted view.
  always_comb begin
    src     = mem;
    src_vld = vld;
    if (shift) begin
      for (int i = 0; i < BANK_DEPTH - 1; i++) begin
        src[i]     = mem[i+1];
        src_vld[i] = vld[i+1];
      end
      src_vld[BANK_DEPTH-1] = 1'b0;
    end
  end

  // Entries not strictly outranked by the new value stay ahead of it (FIFO among equals).
  always_comb begin
    for (int i = 0; i < BANK_DEPTH; i++)
      keep[i] = src_vld[i] && !prio_gt(PRIO_W'(data), PRIO_W'(src[i]), MAX_FIRST != 0);
    mem_nxt = src;
    vld_nxt = src_vld;
    if (ins) begin
      mem_nxt[0] = keep[0] ? src[0] : data;
      vld_nxt[0] = 1'b1;
      for (int i = 1; i < BANK_DEPTH; i++) begin
        mem_nxt[i] = keep[i] ? src[i] : (keep[i-1] ? data : src[i-1]);
        vld_nxt[i] = src_vld[i] | src_vld[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) vld <= '0;
    else       vld <= vld_nxt;
  end

  always_ff @(posedge CLK) begin
    mem <= mem_nxt;
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < BANK_DEPTH; i++)
      if (vld[i]) count = count + CW'(1);
  end

  assign top       = mem[0];
  assign top_valid = vld[0];
  assign full      = vld[BANK_DEPTH-1];

endmodule

// File: rtl/hybrid_pq_banked.sv
// Banked priority queue: least-loaded bank select on insert, registered winner over bank tops.
module hybrid_pq_banked
  import hybrid_pq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 8,
  parameter int MAX_FIRST  = 1
) (
  input  logic                                         CLK,
  input  logic                                         RSTn,
  input  logic                                         i_wrt,
  input  logic                                         i_read,
  input  logic [DATA_WIDTH-1:0]                        i_data,
  output logic                                         o_ready,
  output logic                                         o_valid,
  output logic [DATA_WIDTH-1:0]                        o_data,
  output logic                                         o_empty,
  output logic                                         o_full,
  output logic [$clog2(NUM_BANKS*BANK_DEPTH+1)-1:0]    o_count,
  output logic                                         o_drop
);

  localparam int TOTAL  = NUM_BANKS * BANK_DEPTH;
  localparam int IDX_W  = idx_w(NUM_BANKS);
  localparam int CNT_W  = cnt_w(TOTAL);
  localparam int BCNT_W = cnt_w(BANK_DEPTH);

  logic [DATA_WIDTH-1:0] bank_top  [NUM_BANKS];
  logic                  bank_vld  [NUM_BANKS];
  logic                  bank_full [NUM_BANKS];
  logic [BCNT_W-1:0]     bank_cnt  [NUM_BANKS];
  logic [1:0]            bank_op   [NUM_BANKS];

  state_e                state, state_nxt;
  op_e                   op_nxt;
  logic [IDX_W-1:0]      win_idx, sel_idx, tgt_idx, best_idx;
  logic [BCNT_W-1:0]     sel_cnt;
  logic                  sel_found;
  logic [DATA_WIDTH-1:0] best_data;
  logic                  best_vld;
  logic                  drop_nxt, inc_nxt, dec_nxt, pend_inc, pend_dec;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    pq_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .BANK_DEPTH (BANK_DEPTH),
      .MAX_FIRST  (MAX_FIRST)
    ) u_bank (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .op        (bank_op[b]),
      .data      (i_data),
      .top       (bank_top[b]),
      .top_valid (bank_vld[b]),
      .count     (bank_cnt[b]),
      .full      (bank_full[b])
    );
  end

  // Insert target: least occupied non-full bank, lowest index on ties.
  always_comb begin
    sel_idx   = '0;
    sel_cnt   = '0;
    sel_found = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!bank_full[b] && (!sel_found || bank_cnt[b] < sel_cnt)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(b);
        sel_cnt   = bank_cnt[b];
      end
    end
  end

  // Strict comparison keeps the lower index on equal tops.
  always_comb begin
    best_vld  = 1'b0;
    best_idx  = '0;
    best_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_vld[b] &&
          (!best_vld || prio_gt(PRIO_W'(bank_top[b]), PRIO_W'(best_data), MAX_FIRST != 0))) begin
        best_vld  = 1'b1;
        best_idx  = IDX_W'(b);
        best_data = bank_top[b];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    o_ready   = (state == IDLE);
    op_nxt    = OP_NONE;
    tgt_idx   = sel_idx;
    drop_nxt  = 1'b0;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_wrt || i_read) begin
          state_nxt = UPDATE;
          if (i_wrt && i_read) begin
            if (o_empty) begin
              op_nxt  = OP_PUSH;
              inc_nxt = 1'b1;
            end else begin
              op_nxt  = OP_REPL;
              tgt_idx = win_idx;
            end
          end else if (i_wrt) begin
            if (o_full) drop_nxt = 1'b1;
            else begin
              op_nxt  = OP_PUSH;
              inc_nxt = 1'b1;
            end
          end else begin
            if (o_empty) drop_nxt = 1'b1;
            else begin
              op_nxt  = OP_POP;
              tgt_idx = win_idx;
              dec_nxt = 1'b1;
            end
          end
        end
      end
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      bank_op[b] = (tgt_idx == IDX_W'(b)) ? op_nxt : OP_NONE;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_data   <= '0;
      win_idx  <= '0;
      o_count  <= '0;
      o_drop   <= 1'b0;
      pend_inc <= 1'b0;
      pend_dec <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_drop   <= drop_nxt;
      pend_inc <= inc_nxt;
      pend_dec <= dec_nxt;
      // Banks settled at the accept edge; publish winner and occupancy now.
      if (state == UPDATE) begin
        o_valid <= best_vld;
        o_data  <= best_data;
        win_idx <= best_idx;
        if (pend_inc)      o_count <= o_count + CNT_W'(1);
        else if (pend_dec) o_count <= o_count - CNT_W'(1);
      end
    end
  end

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CNT_W'(TOTAL));

endmodule

// File: tb/tb_hybrid_pq_banked.sv
// Scoreboard bench: a MAX-ordered queue on directed vectors and a MIN-ordered queue against a model.
module tb_hybrid_pq_banked;

  typedef struct {
    logic        vld;
    logic [15:0] val;
  } pop_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        wrt, rd, m_wrt, m_rd;
  logic [15:0] din, m_din;
  logic        ready, valid, empty, full, drop;
  logic        m_ready, m_valid, m_empty, m_full, m_drop;
  logic [15:0] data, m_data;
  logic [5:0]  count, m_count;

  int   n_chk  = 0;
  int   n_fail = 0;
  pop_t exp_q[$];
  pop_t mexp_q[$];
  int   model[$];

  always #5 CLK = ~CLK;

  hybrid_pq_banked #(.DATA_WIDTH(16), .NUM_BANKS(4), .BANK_DEPTH(8), .MAX_FIRST(1)) u_max (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(wrt), .i_read(rd), .i_data(din),
    .o_ready(ready), .o_valid(valid), .o_data(data), .o_empty(empty),
    .o_full(full), .o_count(count), .o_drop(drop)
  );

  hybrid_pq_banked #(.DATA_WIDTH(16), .NUM_BANKS(4), .BANK_DEPTH(8), .MAX_FIRST(0)) u_min (
    .CLK(CLK), .RSTn(RSTn), .i_wrt(m_wrt), .i_read(m_rd), .i_data(m_din),
    .o_ready(m_ready), .o_valid(m_valid), .o_data(m_data), .o_empty(m_empty),
    .o_full(m_full), .o_count(m_count), .o_drop(m_drop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every accepted pop request is compared against the queued expectation.
  always @(negedge CLK) begin : mon_max
    pop_t e;
    if (rd && ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pop_unexpected: got data %0d, expected no pop", data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_valid", valid, e.vld);
        if (e.vld) chk("pop_data", data, e.val);
      end
    end
  end

  always @(negedge CLK) begin : mon_min
    pop_t e;
    if (m_rd && m_ready) begin
      if (mexp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL min_pop_unexpected: got data %0d, expected no pop", m_data);
      end else begin
        e = mexp_q.pop_front();
        chk("min_pop_valid", m_valid, e.vld);
        if (e.vld) chk("min_pop_data", m_data, e.val);
      end
    end
  end

  task automatic settle();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0; wrt = 0; rd = 0; din = '0; m_wrt = 0; m_rd = 0; m_din = '0;
    #3 RSTn = 1'b1;
    exp_q.delete();
    mexp_q.delete();
    model.delete();
  endtask

  task automatic op(input logic w, input logic r, input logic [15:0] d,
                    input logic exp_drop, input logic pv, input logic [15:0] pval);
    int guard = 0;
    @(posedge CLK); #1;
    while (!ready && guard < 10) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("ready_wait", ready, 1);
    wrt = w; rd = r; din = d;
    if (r) exp_q.push_back('{vld: pv, val: pval});
    @(posedge CLK); #1;
    wrt = 0; rd = 0;
    chk("drop", drop, exp_drop);
    chk("busy", ready, 0);
  endtask

  task automatic m_op(input logic w, input logic r, input logic [15:0] d,
                      input logic exp_drop, input logic pv, input logic [15:0] pval);
    int guard = 0;
    @(posedge CLK); #1;
    while (!m_ready && guard < 10) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("min_ready_wait", m_ready, 1);
    m_wrt = w; m_rd = r; m_din = d;
    if (r) mexp_q.push_back('{vld: pv, val: pval});
    @(posedge CLK); #1;
    m_wrt = 0; m_rd = 0;
    chk("min_drop", m_drop, exp_drop);
  endtask

  function automatic int model_min_idx();
    int idx = 0;
    for (int i = 1; i < model.size(); i++)
      if (model[i] < model[idx]) idx = i;
    return idx;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pushv [5];
    logic [15:0] popv  [5];
    pushv = '{16'd5, 16'd0, 16'd9, 16'd9, 16'd3};
    popv  = '{16'd9, 16'd9, 16'd5, 16'd3, 16'd0};

    RSTn = 1'b0; wrt = 0; rd = 0; din = '0; m_wrt = 0; m_rd = 0; m_din = '0;
    #12;
    chk("rst_ready", ready, 1); chk("rst_valid", valid, 0); chk("rst_data", data, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0); chk("rst_count", count, 0);
    chk("rst_drop", drop, 0);
    RSTn = 1'b1;

    // Ordering with duplicates and a zero value
    for (int i = 0; i < 5; i++) op(1, 0, pushv[i], 0, 0, 0);
    settle();
    chk("push5_count", count, 5); chk("push5_top", data, 9);
    for (int i = 0; i < 5; i++) begin
      op(0, 1, 0, 0, 1, popv[i]);
      settle();
      chk("pop_count", count, 4 - i);
    end
    chk("drain_empty", empty, 1); chk("drain_valid", valid, 0);

    // Fill to capacity, overflow and underflow drops
    do_reset();
    for (int i = 0; i < 32; i++) op(1, 0, 16'(i), 0, 0, 0);
    settle();
    chk("fill_count", count, 32); chk("fill_full", full, 1); chk("fill_top", data, 31);
    op(1, 0, 7, 1, 0, 0);
    settle();
    chk("ovf_count", count, 32); chk("ovf_full", full, 1); chk("ovf_drop_clear", drop, 0);
    for (int i = 0; i < 32; i++) op(0, 1, 0, 0, 1, 16'(31 - i));
    settle();
    chk("unfill_count", count, 0); chk("unfill_empty", empty, 1);
    op(0, 1, 0, 1, 0, 0);
    settle();
    chk("udf_count", count, 0);

    // Replace on a populated queue, then on an empty one
    do_reset();
    op(1, 0, 20, 0, 0, 0); op(1, 0, 10, 0, 0, 0); op(1, 0, 15, 0, 0, 0);
    settle();
    chk("repl_pre_top", data, 20);
    op(1, 1, 4, 0, 1, 20);
    settle();
    chk("repl_top", data, 15); chk("repl_count", count, 3);
    op(0, 1, 0, 0, 1, 15); op(0, 1, 0, 0, 1, 10); op(0, 1, 0, 0, 1, 4);
    settle();
    chk("repl_drain", count, 0);
    do_reset();
    op(1, 1, 0, 0, 0, 0);
    settle();
    chk("repl_empty_count", count, 1); chk("repl_empty_valid", valid, 1);
    chk("repl_empty_data", data, 0);

    // Held request: one accept every other cycle
    do_reset();
    @(posedge CLK); #1;
    wrt = 1; din = 11;
    for (int c = 0; c < 6; c++) begin
      chk("ready_toggle", ready, (c % 2 == 0) ? 1 : 0);
      @(posedge CLK); #1;
    end
    wrt = 0;
    chk("hold_count", count, 3); chk("hold_top", data, 11);

    // Reset while UPDATE is in flight
    do_reset();
    op(1, 0, 5, 0, 0, 0);
    settle();
    chk("pre_rst_count", count, 1);
    op(1, 0, 7, 0, 0, 0);
    RSTn = 1'b0; #1;
    chk("mid_rst_ready", ready, 1); chk("mid_rst_valid", valid, 0); chk("mid_rst_data", data, 0);
    chk("mid_rst_empty", empty, 1); chk("mid_rst_full", full, 0); chk("mid_rst_count", count, 0);
    #1 RSTn = 1'b1;
    op(0, 1, 0, 1, 0, 0);
    RSTn = 1'b0; #1;
    chk("mid_rst_drop", drop, 0);
    #1 RSTn = 1'b1;
    settle();
    chk("post_rst_ready", ready, 1); chk("post_rst_count", count, 0);

    // MIN ordering against a reference model
    do_reset();
    for (int k = 0; k < 200; k++) begin
      int          sel, idx;
      logic [15:0] d;
      logic        dr, pv;
      logic [15:0] pval;
      sel = $urandom_range(0, 9);
      d = 16'($urandom_range(0, 15));
      dr = 0; pv = 0; pval = 0;
      if (sel < 5) begin
        dr = (model.size() == 32);
        if (!dr) model.push_back(d);
        m_op(1, 0, d, dr, 0, 0);
      end else if (sel < 8) begin
        dr = (model.size() == 0);
        if (!dr) begin
          idx = model_min_idx(); pv = 1; pval = 16'(model[idx]); model.delete(idx);
        end
        m_op(0, 1, 0, dr, pv, pval);
      end else begin
        if (model.size() != 0) begin
          idx = model_min_idx(); pv = 1; pval = 16'(model[idx]); model.delete(idx);
        end
        model.push_back(d);
        m_op(1, 1, d, 0, pv, pval);
      end
      settle();
      chk("min_count", m_count, model.size());
      chk("min_empty", m_empty, (model.size() == 0) ? 1 : 0);
    end

    chk("max_scoreboard_drained", exp_q.size(), 0);
    chk("min_scoreboard_drained", mexp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hybrid_pq_banked.md
Name: hybrid_pq_banked

Overview:
- Parametrised successor to the two-level hybrid priority queue.
- NUM_BANKS independent sorted storage banks sit behind a registered winner stage that holds the current top element and its bank index.
- Supports MAX or MIN ordering, explicit valid tracking (zero is a legal data value), a ready handshake, an occupancy count and drop reporting.
- Used as the scalable priority-queue primitive for scheduler/sorting datapaths.

Parameters:
- DATA_WIDTH, 16, element width in bits.
- NUM_BANKS, 4, number of storage banks (>=2).
- BANK_DEPTH, 8, elements per bank (>=2).
- MAX_FIRST, 1, 1 = largest value popped first; 0 = smallest value popped first.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  asynchronous active-low reset.
- i_wrt  in  1  insert request.
- i_read  in  1  pop request; i_wrt and i_read together = replace (pop top, insert i_data).
- i_data  in  DATA_WIDTH  insert/replace value.
- o_ready  out  1  op accepted this cycle if any request is high.
- o_valid  out  1  o_data holds a live element.
- o_data  out  DATA_WIDTH  current top element (registered).
- o_empty  out  1  count == 0.
- o_full  out  1  count == NUM_BANKS*BANK_DEPTH.
- o_count  out  $clog2(NUM_BANKS*BANK_DEPTH+1)  occupancy.
- o_drop  out  1  one-cycle pulse: the accepted op was discarded.

Behaviour:
- One clock (CLK); asynchronous active-low reset (RSTn).
- Reset values: o_ready=1, o_valid=0, o_data=0, o_empty=1, o_full=0, o_count=0, o_drop=0; all bank contents invalid; FSM in IDLE.
- FSM states:
  - IDLE: o_ready=1. A request in IDLE is accepted at the clock edge and the FSM moves to UPDATE.
  - UPDATE: o_ready=0; requests are ignored and not queued. At the end of UPDATE the winner register reloads from the bank tops and the FSM returns to IDLE.
  - Throughput is one op per 2 cycles. Latency: an op accepted at edge N is reflected in o_data/o_valid/o_count after edge N+1.
- Pop semantics: the popped value is the o_data visible in the accept cycle. The caller samples o_data when i_read && o_ready.
- Enqueue: targets the non-full bank with the smallest occupancy; ties go to the lowest index.
- Pop: pops the winner bank (winner index register).
- Replace:
  - Winner bank performs pop+insert in one bank op; count is unchanged.
  - If empty: acts as enqueue and count increments.
  - If full: legal.
- Winner selection:
  - Comparison tree over valid bank tops; invalid tops never win.
  - Equal values resolve to the lowest bank index.
  - MAX_FIRST selects the comparator sense.
- Drop cases: enqueue when o_full; pop when o_empty.
  - Op is accepted (FSM still enters UPDATE), state is unchanged, o_drop=1 for the cycle after acceptance.
- o_empty and o_full are derived combinationally from the o_count register.
- Reset mid-UPDATE: everything returns to reset values; the in-flight op is lost.
- Bank behaviour:
  - Each bank is a sorted register array with per-entry valid bits; the top lives at entry 0.
  - Insert: shift-insert at the sorted position in one cycle.
  - Pop: shift toward the top.
  - Replace: remove the top, then insert at the position computed on the remaining entries.
  - Equal values keep FIFO order (new value goes behind existing equals).

Decomposition:
- Package hybrid_pq_pkg:
  - bank-index and count width functions;
  - an op enum (OP_NONE/OP_PUSH/OP_POP/OP_REPL);
  - FSM state enum (IDLE/UPDATE);
  - a priority-compare function parametrised by MAX_FIRST.
- Sub-module pq_bank:
  - Inputs: CLK, RSTn, op, data.
  - Outputs: top, top_valid, count, full.
  - Top level holds bank select, winner tree/registers, FSM, count and drop logic.

Test Plan:
- Reset: assert RSTn=0 mid-UPDATE -> all outputs at reset values; o_ready=1 the next cycle.
- MAX_FIRST=1: push 5, 0, 9, 9, 3 (one per IDLE cycle), then pop ×5 -> popped 9, 9, 5, 3, 0; o_count 5→0; o_empty=1 at end; value 0 is returned, not treated as empty.
- Fill 32 entries (defaults), push 7 -> o_drop pulse, o_count stays 32, o_full=1. Pop on empty -> o_drop pulse, o_count 0.
- Replace:
  - With top 20, replace with 4 -> popped 20; new top is max(4, remaining); count unchanged.
  - Replace on empty with 0 -> o_count=1, o_valid=1, o_data=0.
- Handshake: hold i_wrt high for 6 cycles -> exactly 3 accepted, o_count=3, o_ready toggles 1,0,1,0,...
- MIN_FIRST (MAX_FIRST=0) with random 200-op stream checked against a reference model -> pop order and o_count match every cycle; bank occupancies never differ by more than 1 after pure pushes.
